// File: rtl/hdmi_period_scheduler.sv
// Purpose: raster counters, sync/DE/CTL generation and per-pixel HDMI period selection,
//          including one 44-clock data-island slot per line granted to a packet source.
// Latency: 1 pixclk from internal (cx,cy) to every output. Backpressure: none; island_req is a level, island_grant a 1-clock pulse.
module hdmi_period_scheduler #(
  parameter int H_ACTIVE      = 640,
  parameter int H_TOTAL       = 800,
  parameter int H_SYNC_START  = 656,
  parameter int H_SYNC_END    = 752,
  parameter int V_ACTIVE      = 480,
  parameter int V_TOTAL       = 525,
  parameter int V_SYNC_START  = 490,
  parameter int V_SYNC_END    = 492,
  parameter int ISLAND_OFFSET = 16
) (
  input  logic       pixclk,
  input  logic       rst_n,
  input  logic       island_en,
  input  logic       island_req,
  output logic       island_grant,
  output logic [4:0] island_slot,
  output logic [2:0] period,
  output logic [3:0] ctl,
  output logic       hsync,
  output logic       vsync,
  output logic       de,
  output logic [9:0] x,
  output logic [9:0] y
);

  // Period codes as seen by the encoder stage.
  localparam logic [2:0] P_CTRL     = 3'd0;
  localparam logic [2:0] P_VID_PRE  = 3'd1;
  localparam logic [2:0] P_VID_GB   = 3'd2;
  localparam logic [2:0] P_VID_DATA = 3'd3;
  localparam logic [2:0] P_DI_PRE   = 3'd4;
  localparam logic [2:0] P_DI_GB    = 3'd5;
  localparam logic [2:0] P_DI_DATA  = 3'd6;

  // CTL3..CTL0 patterns for the two preambles.
  localparam logic [3:0] CTL_VID_PRE = 4'b0001;
  localparam logic [3:0] CTL_DI_PRE  = 4'b0101;

  // Raster landmarks in counter width.
  localparam logic [9:0] HA        = 10'(H_ACTIVE);
  localparam logic [9:0] HT_M1     = 10'(H_TOTAL - 1);
  localparam logic [9:0] HS_START  = 10'(H_SYNC_START);
  localparam logic [9:0] HS_END    = 10'(H_SYNC_END);
  localparam logic [9:0] VA        = 10'(V_ACTIVE);
  localparam logic [9:0] VT_M1     = 10'(V_TOTAL - 1);
  localparam logic [9:0] VS_START  = 10'(V_SYNC_START);
  localparam logic [9:0] VS_END    = 10'(V_SYNC_END);
  localparam logic [9:0] VPRE_LO   = 10'(H_TOTAL - 10);
  localparam logic [9:0] VPRE_HI   = 10'(H_TOTAL - 3);
  localparam logic [9:0] VGB_LO    = 10'(H_TOTAL - 2);
  localparam logic [9:0] ISL_START = 10'(H_ACTIVE + ISLAND_OFFSET);

  // Island phase lengths minus one (terminal count of the phase counter).
  localparam logic [4:0] PRE_LAST  = 5'd7;
  localparam logic [4:0] GB_LAST   = 5'd1;
  localparam logic [4:0] DATA_LAST = 5'd31;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PRE  = 3'd1,
    LGB  = 3'd2,
    DATA = 3'd3,
    TGB  = 3'd4
  } isl_state_t;

  // Raster position and island sequencer state.
  logic [9:0] cx_q, cx_d;
  logic [9:0] cy_q, cy_d;
  isl_state_t ist_q, ist_d;
  logic [4:0] icnt_q, icnt_d;

  // Registered outputs.
  logic       grant_q, grant_d;
  logic [4:0] slot_q, slot_d;
  logic [2:0] period_q, period_d;
  logic [3:0] ctl_q, ctl_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       de_q, de_d;
  logic [9:0] x_q, y_q;

  // Combinational helpers.
  logic [9:0] ny;
  logic       next_line_active;
  logic       vid_active;
  logic       start_hit;
  isl_state_t cur_st;
  logic [4:0] cur_cnt;

  // Raster counters: cx wraps every line, cy advances on the cx wrap.
  always_comb begin
    cx_d = cx_q + 10'd1;
    cy_d = cy_q;
    if (cx_q == HT_M1) begin
      cx_d = 10'd0;
      cy_d = (cy_q == VT_M1) ? 10'd0 : cy_q + 10'd1;
    end
  end

  // Island sequencer: the start check is folded into the current phase so the
  // very clock at the start column is already the first preamble clock.
  always_comb begin
    start_hit = (ist_q == IDLE) && (cx_q == ISL_START) && island_en && island_req;
    cur_st    = start_hit ? PRE : ist_q;
    cur_cnt   = start_hit ? 5'd0 : icnt_q;
    ist_d     = cur_st;
    icnt_d    = cur_cnt + 5'd1;
    unique case (cur_st)
      IDLE: begin
        icnt_d = 5'd0;
      end
      PRE: begin
        if (cur_cnt == PRE_LAST) begin
          ist_d  = LGB;
          icnt_d = 5'd0;
        end
      end
      LGB: begin
        if (cur_cnt == GB_LAST) begin
          ist_d  = DATA;
          icnt_d = 5'd0;
        end
      end
      DATA: begin
        if (cur_cnt == DATA_LAST) begin
          ist_d  = TGB;
          icnt_d = 5'd0;
        end
      end
      TGB: begin
        if (cur_cnt == GB_LAST) begin
          ist_d  = IDLE;
          icnt_d = 5'd0;
        end
      end
      default: begin
        ist_d  = IDLE;
        icnt_d = 5'd0;
      end
    endcase
  end

  // Period decode with priority video data > video lead-in > island > control.
  always_comb begin
    ny               = (cy_q == VT_M1) ? 10'd0 : cy_q + 10'd1;
    next_line_active = (ny < VA);
    vid_active       = (cx_q < HA) && (cy_q < VA);
    period_d         = P_CTRL;
    ctl_d            = 4'b0000;
    slot_d           = 5'd0;
    de_d             = 1'b0;
    hsync_d          = (cx_q >= HS_START) && (cx_q < HS_END);
    vsync_d          = (cy_q >= VS_START) && (cy_q < VS_END);
    grant_d          = start_hit;
    if (vid_active) begin
      period_d = P_VID_DATA;
      de_d     = 1'b1;
    end else if (next_line_active && (cx_q >= VPRE_LO) && (cx_q <= VPRE_HI)) begin
      period_d = P_VID_PRE;
      ctl_d    = CTL_VID_PRE;
    end else if (next_line_active && (cx_q >= VGB_LO)) begin
      period_d = P_VID_GB;
    end else begin
      unique case (cur_st)
        PRE: begin
          period_d = P_DI_PRE;
          ctl_d    = CTL_DI_PRE;
        end
        LGB, TGB: begin
          period_d = P_DI_GB;
        end
        DATA: begin
          period_d = P_DI_DATA;
          slot_d   = cur_cnt;
        end
        default: begin
          period_d = P_CTRL;
        end
      endcase
    end
  end

  // State registers; reset abandons any island in progress.
  always_ff @(posedge pixclk) begin
    if (!rst_n) begin
      cx_q   <= 10'd0;
      cy_q   <= 10'd0;
      ist_q  <= IDLE;
      icnt_q <= 5'd0;
    end else begin
      cx_q   <= cx_d;
      cy_q   <= cy_d;
      ist_q  <= ist_d;
      icnt_q <= icnt_d;
    end
  end

  // Output registers, all describing the previous cycle's (cx,cy).
  always_ff @(posedge pixclk) begin
    if (!rst_n) begin
      grant_q  <= 1'b0;
      slot_q   <= 5'd0;
      period_q <= P_CTRL;
      ctl_q    <= 4'b0000;
      hsync_q  <= 1'b0;
      vsync_q  <= 1'b0;
      de_q     <= 1'b0;
      x_q      <= 10'd0;
      y_q      <= 10'd0;
    end else begin
      grant_q  <= grant_d;
      slot_q   <= slot_d;
      period_q <= period_d;
      ctl_q    <= ctl_d;
      hsync_q  <= hsync_d;
      vsync_q  <= vsync_d;
      de_q     <= de_d;
      x_q      <= cx_q;
      y_q      <= cy_q;
    end
  end

  assign island_grant = grant_q;
  assign island_slot  = slot_q;
  assign period       = period_q;
  assign ctl          = ctl_q;
  assign hsync        = hsync_q;
  assign vsync        = vsync_q;
  assign de           = de_q;
  assign x            = x_q;
  assign y            = y_q;

endmodule

// File: tb/tb_hdmi_period_scheduler.sv
// Directed bench for hdmi_period_scheduler; vertical raster shortened to keep runtime small,
// horizontal timing at defaults.
module tb_hdmi_period_scheduler;

  localparam int VA  = 20;
  localparam int VT  = 30;
  localparam int VSS = 24;
  localparam int VSE = 26;

  logic       pixclk = 1'b0;
  logic       rst_n = 1'b0;
  logic       island_en = 1'b0;
  logic       island_req = 1'b0;
  logic       island_grant;
  logic [4:0] island_slot;
  logic [2:0] period;
  logic [3:0] ctl;
  logic       hsync, vsync, de;
  logic [9:0] x, y;

  int total = 0;
  int bad = 0;
  int ex = 0;
  int ey = 0;
  bit first = 1'b1;

  hdmi_period_scheduler #(
    .H_ACTIVE(640), .H_TOTAL(800), .H_SYNC_START(656), .H_SYNC_END(752),
    .V_ACTIVE(VA), .V_TOTAL(VT), .V_SYNC_START(VSS), .V_SYNC_END(VSE),
    .ISLAND_OFFSET(16)
  ) dut (
    .pixclk(pixclk), .rst_n(rst_n), .island_en(island_en), .island_req(island_req),
    .island_grant(island_grant), .island_slot(island_slot), .period(period), .ctl(ctl),
    .hsync(hsync), .vsync(vsync), .de(de), .x(x), .y(y)
  );

  always #20 pixclk = ~pixclk;

  // One clock; (ex,ey) track the raster position the outputs should now show.
  task automatic tick();
    @(posedge pixclk);
    if (rst_n) begin
      if (first) begin
        ex = 0; ey = 0; first = 1'b0;
      end else begin
        ex++;
        if (ex == 800) begin
          ex = 0; ey++;
          if (ey == VT) ey = 0;
        end
      end
    end else begin
      first = 1'b1;
    end
    #1;
  endtask

  function automatic int exp_period(int px, int py, bit isl);
    int nxt;
    nxt = (py + 1) % VT;
    if (px < 640 && py < VA) return 3;
    if (nxt < VA && px >= 790 && px <= 797) return 1;
    if (nxt < VA && px >= 798) return 2;
    if (isl && px >= 656 && px <= 663) return 4;
    if (isl && px >= 664 && px <= 665) return 5;
    if (isl && px >= 666 && px <= 697) return 6;
    if (isl && px >= 698 && px <= 699) return 5;
    return 0;
  endfunction

  function automatic int exp_ctl(int p);
    if (p == 1) return 1;
    if (p == 4) return 5;
    return 0;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; island_en = 1'b0; island_req = 1'b0;
    repeat (3) tick();
    total++; if (period !== 3'd0) begin bad++; $display("FAIL reset_period got=%0d want=0", period); end
    total++; if (ctl !== 4'd0) begin bad++; $display("FAIL reset_ctl got=%0d want=0", ctl); end
    total++; if ({hsync, vsync, de, island_grant} !== 4'b0000) begin bad++; $display("FAIL reset_flags got=%b want=0000", {hsync, vsync, de, island_grant}); end
    total++; if (x !== 10'd0 || y !== 10'd0 || island_slot !== 5'd0) begin bad++; $display("FAIL reset_xy got=%0d,%0d slot=%0d want=0,0 slot=0", x, y, island_slot); end
    rst_n = 1'b1;
    tick();
    total++; if (x !== 10'd0 || y !== 10'd0 || period !== 3'd3 || de !== 1'b1) begin bad++; $display("FAIL first_pixel got x=%0d y=%0d p=%0d de=%0d want 0 0 3 1", x, y, period, de); end
  endtask

  task automatic test_frame();
    int err_xy = 0, err_h = 0, err_v = 0, err_p = 0, err_c = 0;
    int hs_cnt = 0, vs_cnt = 0, de_cnt = 0, gr_cnt = 0;
    int ep;
    island_en = 1'b0; island_req = 1'b1;
    for (int n = 0; n < 800 * VT; n++) begin
      ep = exp_period(ex, ey, 1'b0);
      if (x !== 10'(ex) || y !== 10'(ey)) err_xy++;
      if (hsync !== ((ex >= 656 && ex < 752) ? 1'b1 : 1'b0)) err_h++;
      if (vsync !== ((ey >= VSS && ey < VSE) ? 1'b1 : 1'b0)) err_v++;
      if (period !== 3'(ep)) err_p++;
      if (ctl !== 4'(exp_ctl(ep))) err_c++;
      if (hsync === 1'b1) hs_cnt++;
      if (vsync === 1'b1) vs_cnt++;
      if (de === 1'b1) de_cnt++;
      if (island_grant === 1'b1) gr_cnt++;
      if (ey == 10 && (ex == 790 || ex == 797)) begin
        total++; if (period !== 3'd1 || ctl !== 4'b0001) begin bad++; $display("FAIL vid_pre y=10 x=%0d got p=%0d ctl=%b want 1 0001", ex, period, ctl); end
      end
      if (ey == 10 && (ex == 798 || ex == 799)) begin
        total++; if (period !== 3'd2 || ctl !== 4'd0) begin bad++; $display("FAIL vid_gb y=10 x=%0d got p=%0d ctl=%b want 2 0000", ex, period, ctl); end
      end
      if (ey == 11 && (ex == 0 || ex == 639)) begin
        total++; if (period !== 3'd3 || de !== 1'b1) begin bad++; $display("FAIL vid_data y=11 x=%0d got p=%0d de=%0d want 3 1", ex, period, de); end
      end
      if (ey == VA - 1 && (ex == 790 || ex == 798)) begin
        total++; if (period !== 3'd0) begin bad++; $display("FAIL no_leadin last_active x=%0d got p=%0d want 0", ex, period); end
      end
      if (ey == VT - 1 && ex == 790) begin
        total++; if (period !== 3'd1) begin bad++; $display("FAIL leadin last_line x=790 got p=%0d want 1", period); end
      end
      if (ey == VT - 1 && ex == 799) begin
        total++; if (period !== 3'd2) begin bad++; $display("FAIL leadin last_line x=799 got p=%0d want 2", period); end
      end
      tick();
    end
    total++; if (err_xy != 0) begin bad++; $display("FAIL xy_sweep errors=%0d want 0", err_xy); end
    total++; if (err_h != 0 || hs_cnt != 96 * VT) begin bad++; $display("FAIL hsync errors=%0d count=%0d want 0 %0d", err_h, hs_cnt, 96 * VT); end
    total++; if (err_v != 0 || vs_cnt != 800 * (VSE - VSS)) begin bad++; $display("FAIL vsync errors=%0d count=%0d want 0 %0d", err_v, vs_cnt, 800 * (VSE - VSS)); end
    total++; if (de_cnt != 640 * VA) begin bad++; $display("FAIL de_count got=%0d want=%0d", de_cnt, 640 * VA); end
    total++; if (err_p != 0 || err_c != 0) begin bad++; $display("FAIL frame_period perr=%0d cerr=%0d want 0 0", err_p, err_c); end
    total++; if (gr_cnt != 0) begin bad++; $display("FAIL grant_when_disabled got=%0d want=0", gr_cnt); end
  endtask

  task automatic test_island_held();
    int err_p = 0, err_s = 0, gr_cnt = 0, gr_pos = 0;
    int ep;
    island_en = 1'b1; island_req = 1'b1;
    for (int n = 0; n < 2400; n++) begin
      ep = exp_period(ex, ey, 1'b1);
      if (period !== 3'(ep) || ctl !== 4'(exp_ctl(ep))) err_p++;
      if (island_slot !== 5'((ep == 6) ? ex - 666 : 0)) err_s++;
      if (island_grant === 1'b1) begin
        gr_cnt++;
        if (ex != 656) gr_pos++;
      end
      if (ex == 656) begin
        total++; if (island_grant !== 1'b1 || period !== 3'd4 || ctl !== 4'b0101) begin bad++; $display("FAIL di_start got g=%0d p=%0d ctl=%b want 1 4 0101", island_grant, period, ctl); end
      end
      if (ex == 697) begin
        total++; if (period !== 3'd6 || island_slot !== 5'd31) begin bad++; $display("FAIL di_last_slot got p=%0d slot=%0d want 6 31", period, island_slot); end
      end
      if (ex == 700) begin
        total++; if (period !== 3'd0) begin bad++; $display("FAIL di_end got p=%0d want 0", period); end
      end
      tick();
    end
    total++; if (err_p != 0 || err_s != 0) begin bad++; $display("FAIL island_seq perr=%0d serr=%0d want 0 0", err_p, err_s); end
    total++; if (gr_cnt != 3 || gr_pos != 0) begin bad++; $display("FAIL grant_per_line got=%0d misplaced=%0d want 3 0", gr_cnt, gr_pos); end
  endtask

  task automatic test_late_req();
    int guard = 0, gr_cnt = 0, gx = -1, gy = -1, ly, err_p = 0;
    island_req = 1'b0;
    ly = ey;
    while (ex != 699 && guard < 1000) begin tick(); guard++; end
    total++; if (ex != 699) begin bad++; $display("FAIL late_wait timeout x=%0d want 699", ex); end
    island_req = 1'b1;
    for (int n = 0; n < 901; n++) begin
      tick();
      if (period !== 3'(exp_period(ex, ey, (ey != ly) ? 1'b1 : 1'b0))) err_p++;
      if (island_grant === 1'b1) begin gr_cnt++; gx = ex; gy = ey; end
    end
    total++; if (gr_cnt != 1 || gx != 656 || gy != (ly + 1) % VT) begin bad++; $display("FAIL late_req grants=%0d at x=%0d y=%0d want 1 at 656,%0d", gr_cnt, gx, gy, (ly + 1) % VT); end
    total++; if (err_p != 0) begin bad++; $display("FAIL late_req_period errors=%0d want 0", err_p); end
  endtask

  task automatic test_drop_mid();
    int guard = 0, err_p = 0, gr_cnt = 0;
    while (ex != 671 && guard < 1000) begin tick(); guard++; end
    total++; if (ex != 671 || island_slot !== 5'd5) begin bad++; $display("FAIL drop_wait x=%0d slot=%0d want 671 5", ex, island_slot); end
    island_req = 1'b0; island_en = 1'b0;
    while (ex != 700) begin
      tick();
      if (period !== 3'(exp_period(ex, ey, 1'b1))) err_p++;
      if (exp_period(ex, ey, 1'b1) == 6 && island_slot !== 5'(ex - 666)) err_p++;
    end
    total++; if (err_p != 0) begin bad++; $display("FAIL drop_completes errors=%0d want 0", err_p); end
    island_req = 1'b1;
    err_p = 0;
    for (int n = 0; n < 800; n++) begin
      tick();
      if (island_grant === 1'b1) gr_cnt++;
      if (period !== 3'(exp_period(ex, ey, 1'b0))) err_p++;
    end
    total++; if (gr_cnt != 0 || err_p != 0) begin bad++; $display("FAIL en_off grants=%0d perr=%0d want 0 0", gr_cnt, err_p); end
  endtask

  task automatic test_reset_mid();
    int guard = 0, err_p = 0;
    island_en = 1'b1;
    while (ex != 676 && guard < 1000) begin tick(); guard++; end
    total++; if (ex != 676 || period !== 3'd6 || island_slot !== 5'd10) begin bad++; $display("FAIL rst_wait x=%0d p=%0d slot=%0d want 676 6 10", ex, period, island_slot); end
    rst_n = 1'b0;
    tick();
    total++; if (period !== 3'd0 || ctl !== 4'd0 || island_grant !== 1'b0 || island_slot !== 5'd0) begin bad++; $display("FAIL rst_mid_out got p=%0d ctl=%b g=%0d slot=%0d want 0 0000 0 0", period, ctl, island_grant, island_slot); end
    total++; if (x !== 10'd0 || y !== 10'd0) begin bad++; $display("FAIL rst_mid_xy got=%0d,%0d want 0,0", x, y); end
    rst_n = 1'b1;
    tick();
    total++; if (x !== 10'd0 || y !== 10'd0 || period !== 3'd3) begin bad++; $display("FAIL restart got x=%0d y=%0d p=%0d want 0 0 3", x, y, period); end
    for (int n = 0; n < 720; n++) begin
      if (x !== 10'(ex) || y !== 10'(ey)) err_p++;
      if (period !== 3'(exp_period(ex, ey, 1'b1))) err_p++;
      if (island_grant !== ((ex == 656) ? 1'b1 : 1'b0)) err_p++;
      tick();
    end
    total++; if (err_p != 0) begin bad++; $display("FAIL restart_line errors=%0d want 0", err_p); end
  endtask

  initial begin
    test_reset();
    test_frame();
    test_island_held();
    test_late_req();
    test_drop_mid();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
